// File: rtl/culsans_ar_router.sv
// culsans_ar_router: routes one AXI4 AR/R slave port to NrTargets master ports and answers unmapped reads with DECERR.
// Define CULSANS_AR_ROUTER_STATS_EN to add err_count_o, a saturating count of unmapped read requests.
module culsans_ar_router #(
    parameter int unsigned NrTargets      = 10,
    parameter int unsigned AddrWidth      = 64,
    parameter int unsigned DataWidth      = 64,
    parameter int unsigned IdWidth        = 4,
    parameter int unsigned MaxOutstanding = 8,
    // Rule tables are listed from index NrTargets-1 (Debug) down to index 0 (DRAM)
    parameter logic [NrTargets-1:0][AddrWidth-1:0] AddrBase = {
        64'h0000_0000_0000_0000,
        64'h0000_0000_0001_0000,
        64'h0000_0000_0200_0000,
        64'h0000_0000_0C00_0000,
        64'h0000_0000_1000_0000,
        64'h0000_0000_1800_0000,
        64'h0000_0000_2000_0000,
        64'h0000_0000_3000_0000,
        64'h0000_0000_4000_0000,
        64'h0000_0000_8000_0000
    },
    parameter logic [NrTargets-1:0][AddrWidth-1:0] AddrLength = {
        64'h0000_0000_0000_1000,
        64'h0000_0000_0001_0000,
        64'h0000_0000_000C_0000,
        64'h0000_0000_0400_0000,
        64'h0000_0000_0000_1000,
        64'h0000_0000_0000_1000,
        64'h0000_0000_0080_0000,
        64'h0000_0000_0001_0000,
        64'h0000_0000_0000_1000,
        64'h0000_0000_4000_0000
    }
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
`ifdef CULSANS_AR_ROUTER_STATS_EN
    output logic [15:0]                    err_count_o,
`endif
    input  logic                           slv_ar_valid_i,
    output logic                           slv_ar_ready_o,
    input  logic [IdWidth-1:0]             slv_ar_id_i,
    input  logic [AddrWidth-1:0]           slv_ar_addr_i,
    input  logic [7:0]                     slv_ar_len_i,
    output logic                           slv_r_valid_o,
    input  logic                           slv_r_ready_i,
    output logic [IdWidth-1:0]             slv_r_id_o,
    output logic [DataWidth-1:0]           slv_r_data_o,
    output logic [1:0]                     slv_r_resp_o,
    output logic                           slv_r_last_o,
    output logic [NrTargets-1:0]           mst_ar_valid_o,
    input  logic [NrTargets-1:0]           mst_ar_ready_i,
    output logic [IdWidth-1:0]             mst_ar_id_o,
    output logic [AddrWidth-1:0]           mst_ar_addr_o,
    output logic [7:0]                     mst_ar_len_o,
    input  logic [NrTargets-1:0]           mst_r_valid_i,
    output logic [NrTargets-1:0]           mst_r_ready_o,
    input  logic [NrTargets*IdWidth-1:0]   mst_r_id_i,
    input  logic [NrTargets*DataWidth-1:0] mst_r_data_i,
    input  logic [NrTargets*2-1:0]         mst_r_resp_i,
    input  logic [NrTargets-1:0]           mst_r_last_i
);
    localparam int unsigned TW = $clog2(NrTargets + 1);
    localparam int unsigned CW = $clog2(MaxOutstanding + 1);
    localparam logic [TW-1:0] ErrTgt = TW'(NrTargets);

    typedef enum logic {IDLE, RESP} err_state_e;

    err_state_e           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [TW-1:0]        cur_tgt_q, cur_tgt_d;
    logic [IdWidth-1:0]   err_id_q, err_id_d;
    logic [7:0]           err_beats_q, err_beats_d;
    logic [TW-1:0]        dec;
    logic                 dec_err, cur_err, allowed, ar_hs, r_hs, r_last_hs, err_ar_hs;
    logic                 tgt_ar_ready, tgt_r_valid, tgt_r_last;
    logic [IdWidth-1:0]   tgt_r_id;
    logic [DataWidth-1:0] tgt_r_data;
    logic [1:0]           tgt_r_resp;

    // Widened by one bit so base+length cannot wrap at the top of the address space
    always_comb begin
        dec = ErrTgt;
        for (int t = NrTargets - 1; t >= 0; t--)
            if (AddrLength[t] != '0 && {1'b0, slv_ar_addr_i} >= {1'b0, AddrBase[t]} &&
                {1'b0, slv_ar_addr_i} < {1'b0, AddrBase[t]} + {1'b0, AddrLength[t]})
                dec = TW'(t);
    end

    always_comb begin
        tgt_ar_ready = 1'b0;
        tgt_r_valid  = 1'b0;
        tgt_r_id     = '0;
        tgt_r_data   = '0;
        tgt_r_resp   = '0;
        tgt_r_last   = 1'b0;
        for (int t = 0; t < NrTargets; t++) begin
            if (dec == TW'(t)) tgt_ar_ready = mst_ar_ready_i[t];
            if (cur_tgt_q == TW'(t)) begin
                tgt_r_valid = mst_r_valid_i[t];
                tgt_r_id    = mst_r_id_i[t*IdWidth +: IdWidth];
                tgt_r_data  = mst_r_data_i[t*DataWidth +: DataWidth];
                tgt_r_resp  = mst_r_resp_i[t*2 +: 2];
                tgt_r_last  = mst_r_last_i[t];
            end
        end
    end

    assign dec_err = dec == ErrTgt;
    assign cur_err = cur_tgt_q == ErrTgt;
    // Only one target may own the R channel at a time; DECERR additionally needs an idle error FSM
    assign allowed = (cnt_q == '0 && (!dec_err || state_q == IDLE)) ||
                     (!dec_err && dec == cur_tgt_q && cnt_q < CW'(MaxOutstanding));

    assign slv_ar_ready_o = !rst_i && allowed && (dec_err || tgt_ar_ready);
    assign mst_ar_id_o    = slv_ar_id_i;
    assign mst_ar_addr_o  = slv_ar_addr_i;
    assign mst_ar_len_o   = slv_ar_len_i;

    always_comb begin
        mst_ar_valid_o = '0;
        mst_r_ready_o  = '0;
        for (int t = 0; t < NrTargets; t++) begin
            mst_ar_valid_o[t] = !rst_i && slv_ar_valid_i && allowed && dec == TW'(t);
            mst_r_ready_o[t]  = !rst_i && slv_r_ready_i && cur_tgt_q == TW'(t) && cnt_q != '0;
        end
    end

    assign slv_r_valid_o = !rst_i && cnt_q != '0 && (cur_err ? state_q == RESP : tgt_r_valid);
    assign slv_r_id_o    = cur_err ? err_id_q : tgt_r_id;
    assign slv_r_data_o  = cur_err ? '0 : tgt_r_data;
    assign slv_r_resp_o  = cur_err ? 2'b11 : tgt_r_resp;
    assign slv_r_last_o  = cur_err ? err_beats_q == 8'd0 : tgt_r_last;

    assign ar_hs     = slv_ar_valid_i && slv_ar_ready_o;
    assign r_hs      = slv_r_valid_o && slv_r_ready_i;
    assign r_last_hs = r_hs && slv_r_last_o;
    assign err_ar_hs = ar_hs && dec_err;

    always_comb begin
        cnt_d       = cnt_q + CW'(ar_hs) - CW'(r_last_hs);
        cur_tgt_d   = ar_hs ? dec : cur_tgt_q;
        state_d     = err_ar_hs ? RESP : (r_last_hs && cur_err) ? IDLE : state_q;
        err_id_d    = err_ar_hs ? slv_ar_id_i : err_id_q;
        err_beats_d = err_ar_hs ? slv_ar_len_i :
                      (r_hs && cur_err && !slv_r_last_o) ? err_beats_q - 8'd1 : err_beats_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            cur_tgt_q   <= '0;
            err_id_q    <= '0;
            err_beats_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            cur_tgt_q   <= cur_tgt_d;
            err_id_q    <= err_id_d;
            err_beats_q <= err_beats_d;
        end
    end

`ifdef CULSANS_AR_ROUTER_STATS_EN
    logic [15:0] err_count_q, err_count_d;

    always_comb err_count_d = (err_ar_hs && err_count_q != 16'hFFFF) ? err_count_q + 16'd1 : err_count_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) err_count_q <= '0;
        else       err_count_q <= err_count_d;
    end

    assign err_count_o = err_count_q;
`endif
endmodule

// File: tb/tb_culsans_ar_router.sv
// tb_culsans_ar_router: directed checks of decode, R ordering, DECERR bursts and reset for culsans_ar_router.
module tb_culsans_ar_router;
    localparam int NT = 10;
    localparam int IW = 4;
    localparam int DW = 64;

    logic             clk = 1'b0;
    logic             rst_i;
    logic             slv_ar_valid_i, slv_ar_ready_o;
    logic [IW-1:0]    slv_ar_id_i;
    logic [63:0]      slv_ar_addr_i;
    logic [7:0]       slv_ar_len_i;
    logic             slv_r_valid_o, slv_r_ready_i, slv_r_last_o;
    logic [IW-1:0]    slv_r_id_o;
    logic [DW-1:0]    slv_r_data_o;
    logic [1:0]       slv_r_resp_o;
    logic [NT-1:0]    mst_ar_valid_o, mst_ar_ready_i;
    logic [IW-1:0]    mst_ar_id_o;
    logic [63:0]      mst_ar_addr_o;
    logic [7:0]       mst_ar_len_o;
    logic [NT-1:0]    mst_r_valid_i, mst_r_ready_o, mst_r_last_i;
    logic [NT*IW-1:0] mst_r_id_i;
    logic [NT*DW-1:0] mst_r_data_i;
    logic [NT*2-1:0]  mst_r_resp_i;
`ifdef CULSANS_AR_ROUTER_STATS_EN
    logic [15:0]      err_count_o;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    culsans_ar_router dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
`ifdef CULSANS_AR_ROUTER_STATS_EN
        .err_count_o    (err_count_o),
`endif
        .slv_ar_valid_i (slv_ar_valid_i),
        .slv_ar_ready_o (slv_ar_ready_o),
        .slv_ar_id_i    (slv_ar_id_i),
        .slv_ar_addr_i  (slv_ar_addr_i),
        .slv_ar_len_i   (slv_ar_len_i),
        .slv_r_valid_o  (slv_r_valid_o),
        .slv_r_ready_i  (slv_r_ready_i),
        .slv_r_id_o     (slv_r_id_o),
        .slv_r_data_o   (slv_r_data_o),
        .slv_r_resp_o   (slv_r_resp_o),
        .slv_r_last_o   (slv_r_last_o),
        .mst_ar_valid_o (mst_ar_valid_o),
        .mst_ar_ready_i (mst_ar_ready_i),
        .mst_ar_id_o    (mst_ar_id_o),
        .mst_ar_addr_o  (mst_ar_addr_o),
        .mst_ar_len_o   (mst_ar_len_o),
        .mst_r_valid_i  (mst_r_valid_i),
        .mst_r_ready_o  (mst_r_ready_o),
        .mst_r_id_i     (mst_r_id_i),
        .mst_r_data_i   (mst_r_data_i),
        .mst_r_resp_i   (mst_r_resp_i),
        .mst_r_last_i   (mst_r_last_i)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_ar(input string tag, input logic [63:0] addr, input logic [IW-1:0] id,
                           input logic [7:0] len, input logic [NT-1:0] exp_vld);
        slv_ar_valid_i = 1'b1;
        slv_ar_addr_i  = addr;
        slv_ar_id_i    = id;
        slv_ar_len_i   = len;
        #1;
        check({tag, "/ar_ready"}, slv_ar_ready_o, 1);
        check({tag, "/ar_valid"}, mst_ar_valid_o, exp_vld);
        check({tag, "/ar_payload"}, {mst_ar_addr_o ^ addr, 52'd0, mst_ar_len_o, mst_ar_id_o}, {64'd0, 52'd0, len, id});
        check({tag, "/r_valid"}, slv_r_valid_o, 0);
        tick;
        slv_ar_valid_i = 1'b0;
    endtask

    // Other slots carry distinct junk so a wrong mux select is visible
    task automatic r_drive(input string tag, input int t, input logic [IW-1:0] id, input logic [DW-1:0] data,
                           input logic [1:0] resp, input logic last);
        logic [NT-1:0] onehot;
        onehot = '0;
        onehot[t] = 1'b1;
        mst_r_valid_i = onehot;
        mst_r_id_i    = {NT{4'hA}};
        mst_r_data_i  = {NT{64'hDEAD_BEEF_0BAD_F00D}};
        mst_r_resp_i  = {NT{2'b10}};
        mst_r_last_i  = last ? '0 : '1;
        mst_r_id_i[t*IW +: IW] = id;
        mst_r_data_i[t*DW +: DW] = data;
        mst_r_resp_i[t*2 +: 2] = resp;
        mst_r_last_i[t] = last;
        slv_r_ready_i = 1'b1;
        #1;
        check({tag, "/r_valid"}, slv_r_valid_o, 1);
        check({tag, "/r_id"}, slv_r_id_o, id);
        check({tag, "/r_data"}, slv_r_data_o, data);
        check({tag, "/r_resp_last"}, {slv_r_resp_o, slv_r_last_o}, {resp, last});
        check({tag, "/r_ready"}, mst_r_ready_o, onehot);
    endtask

    task automatic r_clear;
        mst_r_valid_i = '0;
        slv_r_ready_i = 1'b0;
    endtask

    task automatic r_beat(input string tag, input int t, input logic [IW-1:0] id, input logic [DW-1:0] data,
                          input logic [1:0] resp, input logic last);
        r_drive(tag, t, id, data, resp, last);
        tick;
        r_clear;
    endtask

    task automatic err_beat(input string tag, input logic [IW-1:0] id, input logic last);
        mst_r_valid_i = '1;
        slv_r_ready_i = 1'b1;
        #1;
        check({tag, "/err_valid"}, slv_r_valid_o, 1);
        check({tag, "/err_resp"}, slv_r_resp_o, 2'b11);
        check({tag, "/err_data"}, slv_r_data_o, 0);
        check({tag, "/err_id_last"}, {slv_r_id_o, slv_r_last_o}, {id, last});
        check({tag, "/err_no_mst_ready"}, mst_r_ready_o, 0);
        tick;
        r_clear;
    endtask

    task automatic idle_check(input string tag);
        mst_r_valid_i = '1;
        slv_r_ready_i = 1'b1;
        #1;
        check({tag, "/idle_r_valid"}, slv_r_valid_o, 0);
        check({tag, "/idle_r_ready"}, mst_r_ready_o, 0);
        r_clear;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        rst_i = 1'b1;
        slv_ar_valid_i = 1'b1;
        slv_ar_addr_i = 64'h8000_0000;
        slv_ar_id_i = '0;
        slv_ar_len_i = '0;
        slv_r_ready_i = 1'b1;
        mst_ar_ready_i = '1;
        mst_r_valid_i = '1;
        mst_r_id_i = '0;
        mst_r_data_i = '0;
        mst_r_resp_i = '0;
        mst_r_last_i = '1;
        tick;
        tick;
        check("rst/ar_ready", slv_ar_ready_o, 0);
        check("rst/ar_valid", mst_ar_valid_o, 0);
        check("rst/r_valid", slv_r_valid_o, 0);
        check("rst/r_ready", mst_r_ready_o, 0);
`ifdef CULSANS_AR_ROUTER_STATS_EN
        check("rst/err_count", err_count_o, 0);
`endif
        slv_ar_valid_i = 1'b0;
        r_clear;
        rst_i = 1'b0;
        tick;

        // 1: DRAM burst; ready follows the target's ready
        mst_ar_ready_i[0] = 1'b0;
        slv_ar_valid_i = 1'b1;
        slv_ar_addr_i = 64'h8000_0000;
        #1;
        check("t1/bp_valid", mst_ar_valid_o, 10'b1);
        check("t1/bp_ready", slv_ar_ready_o, 0);
        tick;
        mst_ar_ready_i = '1;
        send_ar("t1", 64'h8000_0000, 4'd2, 8'd3, 10'b1);
        for (int k = 0; k < 4; k++) r_beat("t1b", 0, 4'd2, 64'h1000 + 64'(k), 2'b00, k == 3);
        idle_check("t1");

        // 2: target switch waits for the last outstanding DRAM read
        send_ar("t2a", 64'h8000_1000, 4'd1, 8'd0, 10'b1);
        send_ar("t2b", 64'h8000_2000, 4'd4, 8'd0, 10'b1);
        slv_ar_valid_i = 1'b1;
        slv_ar_addr_i = 64'h1000_0000;
        slv_ar_id_i = 4'd6;
        slv_ar_len_i = 8'd0;
        #1;
        check("t2/stall0", {slv_ar_ready_o, mst_ar_valid_o}, 0);
        r_drive("t2r1", 0, 4'd1, 64'h11, 2'b00, 1'b1);
        check("t2/stall1", slv_ar_ready_o, 0);
        tick;
        r_clear;
        r_drive("t2r2", 0, 4'd4, 64'h22, 2'b00, 1'b1);
        check("t2/stall2", slv_ar_ready_o, 0);
        tick;
        r_clear;
        #1;
        check("t2/uart_ready", slv_ar_ready_o, 1);
        check("t2/uart_valid", mst_ar_valid_o, 10'b1 << 5);
        tick;
        slv_ar_valid_i = 1'b0;
        r_beat("t2r3", 5, 4'd6, 64'h5555_0000, 2'b01, 1'b1);
        idle_check("t2");

        // 3: unmapped read answered with a two-beat DECERR burst
        send_ar("t3", 64'h5000_0000, 4'd3, 8'd1, 10'b0);
        err_beat("t3b0", 4'd3, 1'b0);
        err_beat("t3b1", 4'd3, 1'b1);
        idle_check("t3");
`ifdef CULSANS_AR_ROUTER_STATS_EN
        check("t3/err_count", err_count_o, 1);
`endif

        // 4: outstanding limit and simultaneous AR + last-R
        for (int i = 0; i < 8; i++) send_ar("t4", 64'h8000_0000 + 64'(i), 4'(i), 8'd0, 10'b1);
        slv_ar_valid_i = 1'b1;
        slv_ar_addr_i = 64'h8000_0100;
        slv_ar_id_i = 4'd8;
        #1;
        check("t4/full", slv_ar_ready_o, 0);
        r_drive("t4r0", 0, 4'd0, 64'h40, 2'b00, 1'b1);
        check("t4/full_during_r", slv_ar_ready_o, 0);
        tick;
        r_clear;
        r_drive("t4r1", 0, 4'd1, 64'h41, 2'b00, 1'b1);
        check("t4/same_cycle", slv_ar_ready_o, 1);
        tick;
        r_clear;
        slv_ar_valid_i = 1'b0;
        send_ar("t4refill", 64'h8000_0200, 4'd9, 8'd0, 10'b1);
        slv_ar_valid_i = 1'b1;
        slv_ar_addr_i = 64'h8000_0300;
        slv_ar_id_i = 4'd10;
        #1;
        check("t4/full_again", slv_ar_ready_o, 0);
        slv_ar_valid_i = 1'b0;
        for (int i = 2; i < 10; i++) r_beat("t4drain", 0, 4'(i), 64'h40 + 64'(i), 2'b00, 1'b1);
        idle_check("t4");

        // 5: rule boundaries
        send_ar("t5rom", 64'h0001_FFFF, 4'd1, 8'd0, 10'b1 << 8);
        r_beat("t5rom", 8, 4'd1, 64'hAB, 2'b00, 1'b1);
        send_ar("t5gap", 64'h0002_0000, 4'd2, 8'd0, 10'b0);
        err_beat("t5gap", 4'd2, 1'b1);
        send_ar("t5dram", 64'hBFFF_FFFF, 4'd3, 8'd0, 10'b1);
        r_beat("t5dram", 0, 4'd3, 64'hCD, 2'b00, 1'b1);
        send_ar("t5top", 64'hC000_0000, 4'd4, 8'd0, 10'b0);
        err_beat("t5top", 4'd4, 1'b1);
        idle_check("t5");
`ifdef CULSANS_AR_ROUTER_STATS_EN
        check("t5/err_count", err_count_o, 3);
`endif

        // 6: reset in the middle of a DECERR burst
        send_ar("t6", 64'h5000_0000, 4'd7, 8'd3, 10'b0);
        rst_i = 1'b1;
        slv_r_ready_i = 1'b1;
        #1;
        check("t6/rst_r_valid", slv_r_valid_o, 0);
        tick;
        rst_i = 1'b0;
        #1;
        check("t6/post_rst_r_valid", slv_r_valid_o, 0);
`ifdef CULSANS_AR_ROUTER_STATS_EN
        check("t6/err_count", err_count_o, 0);
`endif
        r_clear;
        send_ar("t6dram", 64'h8000_0040, 4'd5, 8'd0, 10'b1);
        r_beat("t6dram", 0, 4'd5, 64'hEF, 2'b00, 1'b1);
        idle_check("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
